lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Shares the 16-bit 8080-style LCD write bus (cs_n, d_c_n, wr_n, databus) between two requesters.
//  The requesters are a CPU command port (commands and parameters) and a DMA pixel stream port.
//  Generates wr_n strobe timing and grants the bus one word at a time.
//  Pixel bursts are bounded so the command port cannot be starved during frame streaming.
//  Sits between the CPU/DMA masters and the LCD conduit pins.
// PARAMETERS
//  DATA_W      16  width of databus and of both requester data ports
//  WR_LOW_CYC   2  cycles wr_n is held low per word (>=1)
//  WR_HIGH_CYC  2  cycles wr_n is held high after the rising edge, data held (>=1)
//  BURST_MAX    8  max consecutive pixel grants while a command is pending (>=1)
// PORTS
//  clk            in   1       system clock; all logic on rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  cmd_valid      in   1       command word available
//  cmd_ready      out  1       command word accepted this cycle
//  cmd_dc         in   1       0 = command byte, 1 = parameter/data
//  cmd_data       in   DATA_W  command word
//  pix_valid      in   1       pixel word available
//  pix_ready      out  1       pixel word accepted this cycle
//  pix_data       in   DATA_W  pixel word (always sent with d_c_n = 1)
//  lcd_cs_n       out  1       chip select, low while a transfer is in flight
//  lcd_d_c_n      out  1       data/command select
//  lcd_wr_n       out  1       write strobe; LCD latches on rising edge
//  lcd_databus    out  DATA_W  bus data
//  busy           out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset values (async, immediate): cs_n=1, wr_n=1, d_c_n=1, databus=0,
//    cmd_ready=0, pix_ready=0, busy=0, state=IDLE, burst_cnt=0, last_cmd=0.
//  - FSM: IDLE -> SETUP (1 cyc) -> WR_LOW (WR_LOW_CYC) -> WR_HIGH (WR_HIGH_CYC) -> IDLE.
//  - Acceptance happens only in IDLE. The ready of the granted port is combinational:
//    high in IDLE when that port's valid is high and it wins arbitration.
//  - A transfer happens when valid && ready. The same edge registers databus/d_c_n, drives cs_n=0 and enters SETUP.
//  - SETUP: wr_n=1, data stable. WR_LOW: wr_n=0. WR_HIGH: wr_n=1, data/d_c_n held.
//  - On leaving WR_HIGH: cs_n returns to 1. IDLE always lasts >=1 cycle.
//  - Per-word period: 2 + WR_LOW_CYC + WR_HIGH_CYC cycles (6 at defaults).
//  - Arbitration in IDLE:
//      only one valid -> that port wins.
//      both valid     -> pix wins if last_cmd=1, or if (last_cmd=0 and burst_cnt<BURST_MAX);
//                        otherwise cmd wins.
//  - burst_cnt: +1 on each pix grant, saturating at BURST_MAX. Cleared on each cmd grant.
//  - last_cmd: set on cmd grant, cleared on pix grant.
//  - Width of burst_cnt is $clog2(BURST_MAX+1).
//  - Valid deasserted mid-transfer has no effect: the word is already latched.
//  - Data inputs are sampled only at acceptance.
//  - Reset asserted mid-transfer aborts the word. Outputs go to reset values without a wr_n edge.
//  - Both readies are never high in the same cycle.
// STRUCTURE
//  - Shared package lcd_bus_pkg:
//      state enum {IDLE, SETUP, WR_LOW, WR_HIGH}
//      DATA_W default constant
//      D_C_CMD=0, D_C_DATA=1
//  - One sub-module lcd_wr_timer: loadable down-counter that flags the last cycle of the
//    WR_LOW and WR_HIGH phases. Width is $clog2(max(WR_LOW_CYC, WR_HIGH_CYC)+1).
//  - Arbiter, burst counter and FSM live in the top.
// TESTING
//  1. Reset then idle: all outputs at reset values; with no valid for 20 cycles, busy=0 and cs_n=1.
//  2. Single cmd 0x002C, cmd_dc=0:
//     - cmd_ready high 1 cycle, then cs_n=0 and d_c_n=0 for 5 cycles;
//     - wr_n low exactly cycles 2-3 after accept; databus=0x002C throughout.
//  3. Pixel stream 0x0001..0x0010 with pix_valid held high:
//     - 16 words in order, each with d_c_n=1, one accept every 6 cycles;
//     - 16 wr_n rising edges.
//  4. Contention: pix_valid held high, cmd_valid raised after the 2nd pixel grant:
//     - pixels 3..8 granted (burst_cnt reaches 8), then cmd granted;
//     - then pixels resume.
//  5. Tie from reset: both valid at the first IDLE -> pix granted first, since last_cmd=0 and burst_cnt=0.
//  6. Reset in WR_LOW: wr_n, cs_n and d_c_n go to 1 immediately.
//     - After release, the aborted word is not re-sent;
//     - a following accepted word has normal timing.

Source files
------------

// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the two-master 8080-style LCD write bus arbiter.
// Combinational helpers only: no latency, no backpressure.
package lcd_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      WR_LOW  = 2'd2,
      WR_HIGH = 2'd3
   } state_t;

   localparam int   LCD_DATA_W = 16;
   localparam logic D_C_CMD    = 1'b0;
   localparam logic D_C_DATA   = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_wr_timer.sv
// Loadable down-counter; o_last flags the final cycle of the phase just loaded.
// Load takes effect on the next edge; the count holds at zero; no backpressure.
module lcd_wr_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_last
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_last = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates CPU command and DMA pixel words onto one LCD write bus, one word per 2+WR_LOW_CYC+WR_HIGH_CYC cycles.
// Readies are combinational and only high in IDLE; pixel bursts are capped at BURST_MAX while a command waits.
module lcd_bus_arbiter
   import lcd_bus_pkg::*;
#(
   parameter int DATA_W      = LCD_DATA_W,
   parameter int WR_LOW_CYC  = 2,
   parameter int WR_HIGH_CYC = 2,
   parameter int BURST_MAX   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dc,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [DATA_W-1:0] pix_data,
   output logic              lcd_cs_n,
   output logic              lcd_d_c_n,
   output logic              lcd_wr_n,
   output logic [DATA_W-1:0] lcd_databus,
   output logic              busy
);

   localparam int TMR_W   = $clog2(max_int(WR_LOW_CYC, WR_HIGH_CYC) + 1);
   localparam int BURST_W = $clog2(BURST_MAX + 1);
   localparam logic [TMR_W-1:0]   LOW_LOAD  = TMR_W'(WR_LOW_CYC - 1);
   localparam logic [TMR_W-1:0]   HIGH_LOAD = TMR_W'(WR_HIGH_CYC - 1);
   localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_cs_n;
   logic                r_wr_n;
   logic                r_d_c_n;
   logic [DATA_W-1:0]   r_databus;
   logic [BURST_W-1:0]  r_burst_cnt;
   logic                r_last_cmd;
   logic                w_pix_win;
   logic                w_cmd_acc;
   logic                w_pix_acc;
   logic                w_tmr_load;
   logic [TMR_W-1:0]    w_tmr_val;
   logic                w_tmr_last;

   // Pixels yield to a waiting command only once the burst cap is reached
   // and the previous grant was not already a command.
   assign w_pix_win = pix_valid &&
                      (!cmd_valid || r_last_cmd || (r_burst_cnt < BURST_LIM));

   lcd_wr_timer #(
      .CNT_W (TMR_W)
   ) u_wr_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_last     (w_tmr_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_load  = 1'b0;
      w_tmr_val   = '0;
      w_cmd_acc   = 1'b0;
      w_pix_acc   = 1'b0;
      case (r_state)
         IDLE: begin
            w_pix_acc = w_pix_win;
            w_cmd_acc = cmd_valid && !w_pix_win;
            if (w_pix_acc || w_cmd_acc) begin
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            w_state_nxt = WR_LOW;
            w_tmr_load  = 1'b1;
            w_tmr_val   = LOW_LOAD;
         end
         WR_LOW: begin
            if (w_tmr_last) begin
               w_state_nxt = WR_HIGH;
               w_tmr_load  = 1'b1;
               w_tmr_val   = HIGH_LOAD;
            end
         end
         WR_HIGH: begin
            if (w_tmr_last) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pin outputs are registered from the next state so they switch cleanly with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cs_n      <= 1'b1;
         r_wr_n      <= 1'b1;
         r_d_c_n     <= 1'b1;
         r_databus   <= '0;
         r_burst_cnt <= '0;
         r_last_cmd  <= 1'b0;
      end else begin
         r_cs_n <= (w_state_nxt == IDLE);
         r_wr_n <= (w_state_nxt != WR_LOW);
         if (w_cmd_acc) begin
            r_databus   <= cmd_data;
            r_d_c_n     <= cmd_dc;
            r_last_cmd  <= 1'b1;
            r_burst_cnt <= '0;
         end else if (w_pix_acc) begin
            r_databus  <= pix_data;
            r_d_c_n    <= D_C_DATA;
            r_last_cmd <= 1'b0;
            if (r_burst_cnt < BURST_LIM) begin
               r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            end
         end
      end
   end

   assign cmd_ready   = w_cmd_acc;
   assign pix_ready   = w_pix_acc;
   assign lcd_cs_n    = r_cs_n;
   assign lcd_wr_n    = r_wr_n;
   assign lcd_d_c_n   = r_d_c_n;
   assign lcd_databus = r_databus;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: arbitration vector table plus hand-written timing, stream, contention and reset-abort sequences.
module tb_lcd_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dc = 1'b0;
   logic [15:0] cmd_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [15:0] pix_data = '0;
   logic        lcd_cs_n;
   logic        lcd_d_c_n;
   logic        lcd_wr_n;
   logic [15:0] lcd_databus;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;
   int n_rise = 0;

   typedef struct {
      logic        cv;
      logic        cdc;
      logic [15:0] cd;
      logic        pv;
      logic [15:0] pd;
      logic        exp_cr;
      logic        exp_pr;
      logic        exp_dc;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   lcd_bus_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_dc      (cmd_dc),
      .cmd_data    (cmd_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_data    (pix_data),
      .lcd_cs_n    (lcd_cs_n),
      .lcd_d_c_n   (lcd_d_c_n),
      .lcd_wr_n    (lcd_wr_n),
      .lcd_databus (lcd_databus),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge lcd_wr_n) n_rise++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Returns at a falling edge with the DUT idle, or records a timeout.
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle_timeout", busy, 1'b0);
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      pix_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One word with full per-cycle pin timing check.
   task automatic send_word(input string tag, input bit use_cmd, input logic dc, input logic [15:0] d);
      logic exp_dc;
      exp_dc = use_cmd ? dc : 1'b1;
      wait_idle();
      if (use_cmd) begin
         cmd_valid = 1'b1; cmd_dc = dc; cmd_data = d;
      end else begin
         pix_valid = 1'b1; pix_data = d;
      end
      #1;
      chk({tag, "_cmd_rdy"}, cmd_ready, use_cmd);
      chk({tag, "_pix_rdy"}, pix_ready, !use_cmd);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      pix_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("%s_cs_n_c%0d", tag, k), lcd_cs_n, (k <= 5) ? 1'b0 : 1'b1);
         chk($sformatf("%s_wr_n_c%0d", tag, k), lcd_wr_n, (k == 2 || k == 3) ? 1'b0 : 1'b1);
         chk($sformatf("%s_busy_c%0d", tag, k), busy, (k <= 5) ? 1'b1 : 1'b0);
         if (k <= 5) begin
            chk($sformatf("%s_data_c%0d", tag, k), lcd_databus, d);
            chk($sformatf("%s_dc_c%0d", tag, k), lcd_d_c_n, exp_dc);
         end
      end
   endtask

   initial begin : main
      int bad;
      int base;
      int nacc;
      int last_acc;
      int ng;
      bit pend;
      bit pend_c;
      bit raised;
      logic [15:0] exp_w;
      bit exp_cmd[10];

      //           cv  cdc  cd        pv  pd        cr  pr  dc  data
      vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[1] = '{1'b1, 1'b0, 16'h0011, 1'b1, 16'hA001, 1'b0, 1'b1, 1'b1, 16'hA001};
      vecs[2] = '{1'b1, 1'b0, 16'h002C, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h002C};
      vecs[3] = '{1'b1, 1'b1, 16'h0033, 1'b1, 16'hA002, 1'b0, 1'b1, 1'b1, 16'hA002};
      vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA003, 1'b0, 1'b1, 1'b1, 16'hA003};
      vecs[5] = '{1'b1, 1'b1, 16'h0055, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0055};
      exp_cmd = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

      // Reset values, then a quiet idle period
      #2 reset_n = 1'b0;
      #1;
      chk("rst_cs_n", lcd_cs_n, 1'b1);
      chk("rst_wr_n", lcd_wr_n, 1'b1);
      chk("rst_dc", lcd_d_c_n, 1'b1);
      chk("rst_data", lcd_databus, 16'h0000);
      chk("rst_cmd_rdy", cmd_ready, 1'b0);
      chk("rst_pix_rdy", pix_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy || !lcd_cs_n || cmd_ready || pix_ready) bad++;
      end
      chk("idle_20_cycles", bad, 0);

      // Arbitration table; first entry with both valid is the tie from reset
      for (int i = 0; i < 6; i++) begin
         wait_idle();
         cmd_valid = vecs[i].cv; cmd_dc = vecs[i].cdc; cmd_data = vecs[i].cd;
         pix_valid = vecs[i].pv; pix_data = vecs[i].pd;
         #1;
         chk($sformatf("vec%0d_cmd_rdy", i), cmd_ready, vecs[i].exp_cr);
         chk($sformatf("vec%0d_pix_rdy", i), pix_ready, vecs[i].exp_pr);
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         pix_valid = 1'b0;
         if (vecs[i].exp_cr || vecs[i].exp_pr) begin
            @(negedge clk);
            chk($sformatf("vec%0d_data", i), lcd_databus, vecs[i].exp_data);
            chk($sformatf("vec%0d_dc", i), lcd_d_c_n, vecs[i].exp_dc);
            chk($sformatf("vec%0d_cs_n", i), lcd_cs_n, 1'b0);
         end
      end

      send_word("cmd2c", 1'b1, 1'b0, 16'h002C);

      // Pixel stream 1..16 with valid held high
      wait_idle();
      base = n_rise; nacc = 0; last_acc = 0; pend = 0; exp_w = '0;
      pix_valid = 1'b1;
      pix_data = 16'h0001;
      for (int c = 0; c < 200 && (nacc < 16 || pend); c++) begin
         if (pend) begin
            chk($sformatf("stream_data%0d", nacc), lcd_databus, exp_w);
            chk($sformatf("stream_dc%0d", nacc), lcd_d_c_n, 1'b1);
            pend = 0;
            if (nacc < 16) pix_data = 16'(nacc + 1);
            else pix_valid = 1'b0;
         end
         #1;
         if (pix_ready && nacc < 16) begin
            if (nacc > 0) chk($sformatf("stream_period%0d", nacc), c - last_acc, 6);
            last_acc = c;
            exp_w = pix_data;
            nacc++;
            pend = 1;
         end
         @(negedge clk);
      end
      pix_valid = 1'b0;
      chk("stream_count", nacc, 16);
      wait_idle();
      chk("stream_wr_rises", n_rise - base, 16);

      // Contention: command raised after the second pixel grant
      do_reset();
      wait_idle();
      ng = 0; pend = 0; pend_c = 0; raised = 0;
      cmd_dc = 1'b0; cmd_data = 16'h002A;
      pix_valid = 1'b1; pix_data = 16'h0100;
      for (int c = 0; c < 300 && ng < 10; c++) begin
         if (pend_c) cmd_valid = 1'b0;
         if (pend) pix_data = pix_data + 16'h0001;
         pend_c = 0; pend = 0;
         if (ng == 2 && !raised) begin
            cmd_valid = 1'b1;
            raised = 1;
         end
         #1;
         if (cmd_ready || pix_ready) begin
            chk($sformatf("cont_both_rdy%0d", ng), cmd_ready & pix_ready, 1'b0);
            chk($sformatf("cont_grant%0d_is_cmd", ng), cmd_ready, exp_cmd[ng]);
            if (cmd_ready) pend_c = 1;
            else pend = 1;
            ng++;
         end
         @(negedge clk);
      end
      pix_valid = 1'b0;
      cmd_valid = 1'b0;
      chk("cont_grant_count", ng, 10);

      // Reset during WR_LOW aborts the word
      wait_idle();
      cmd_valid = 1'b1; cmd_dc = 1'b0; cmd_data = 16'h00AA;
      #1;
      chk("abort_cmd_rdy", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_in_wr_low", lcd_wr_n, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("abort_wr_n", lcd_wr_n, 1'b1);
      chk("abort_cs_n", lcd_cs_n, 1'b1);
      chk("abort_dc", lcd_d_c_n, 1'b1);
      chk("abort_data", lcd_databus, 16'h0000);
      chk("abort_busy", busy, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (!lcd_cs_n || busy) bad++;
      end
      chk("abort_not_resent", bad, 0);
      send_word("after_abort", 1'b0, 1'b1, 16'h5A5A);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
